// File: rtl/decode_pkg.sv
// Shared types and opcode constants for the instruction decode stage.
package decode_pkg;

    // RV32 major opcodes, inst[6:2]
    localparam logic [4:0] LOAD   = 5'h00;
    localparam logic [4:0] OP_IMM = 5'h04;
    localparam logic [4:0] AUIPC  = 5'h05;
    localparam logic [4:0] STORE  = 5'h08;
    localparam logic [4:0] OP     = 5'h0C;
    localparam logic [4:0] LUI    = 5'h0D;
    localparam logic [4:0] BRANCH = 5'h18;
    localparam logic [4:0] JALR   = 5'h19;
    localparam logic [4:0] JAL    = 5'h1B;
    localparam logic [4:0] SYSTEM = 5'h1C;

    typedef struct packed {
        logic [4:0]  opcode;
        logic [2:0]  func3;
        logic [1:0]  func7;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [21:0] csr_info;
        logic [11:0] csr_imm;
        logic [31:0] csr_op_imm;
        logic        illegal;
    } dec_fields_t;

    typedef enum logic {IDLE, ISSUE} dec_state_t;

endpackage

// File: rtl/inst_field_extract.sv
// Pure bit-select field extraction for one 32-bit instruction.
module inst_field_extract
    import decode_pkg::*;
(
    input  logic [31:0] inst,
    output dec_fields_t fields
);

    // Every field is a fixed slice; illegal flags non-32-bit (compressed) encodings
    always_comb begin
        fields            = '0;
        fields.opcode     = inst[6:2];
        fields.func3      = inst[14:12];
        fields.func7      = {inst[30], inst[25]};
        fields.rs1        = inst[19:15];
        fields.rs2        = inst[24:20];
        fields.rd         = inst[11:7];
        fields.csr_info   = {inst[31:20], inst[14:12], inst[6:0]};
        fields.csr_imm    = inst[31:20];
        fields.csr_op_imm = {27'd0, inst[19:15]};
        fields.illegal    = (inst[1:0] != 2'b11);
    end

endmodule

// File: rtl/multi_lane_decode_stage.sv
// Registered decode stage: holds a multi-lane fetch word and issues one
// decoded lane per cycle with valid/ready flow control and flush.
module multi_lane_decode_stage
    import decode_pkg::*;
#(
    parameter int unsigned LANES = 2,
    parameter int unsigned PC_W  = 32,
    localparam int unsigned CNT_W = $clog2(LANES + 1)
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [LANES*32-1:0]   in_inst,
    input  logic [PC_W-1:0]       in_pc,
    input  logic [CNT_W-1:0]      in_cnt,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [PC_W-1:0]       out_pc,
    output logic [4:0]            out_opcode,
    output logic [2:0]            out_func3,
    output logic [1:0]            out_func7,
    output logic [4:0]            out_rs1,
    output logic [4:0]            out_rs2,
    output logic [4:0]            out_rd,
    output logic [21:0]           out_csr_info,
    output logic [11:0]           out_csr_imm,
    output logic [31:0]           out_csr_op_imm,
    output logic                  out_illegal
);

    localparam int unsigned LANE_W = (LANES > 1) ? $clog2(LANES) : 1;

    dec_state_t            state_q;
    logic [LANES*32-1:0]   inst_q;
    logic [PC_W-1:0]       pc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic [LANE_W-1:0]     lane_q;
    logic                  out_valid_q;
    logic [PC_W-1:0]       out_pc_q;
    dec_fields_t           fields_q;

    logic                  hs;
    logic                  accept;
    logic                  more_lanes;
    logic                  last_hs;
    logic [CNT_W-1:0]      next_lane;
    logic [CNT_W-1:0]      eff_cnt;
    logic [LANE_W-1:0]     src_sel;
    logic [31:0]           src_inst;
    dec_fields_t           src_fields;

    // Handshake decode and lane mux: a new word always presents its lane 0,
    // otherwise the held word's next lane is presented
    always_comb begin
        hs         = out_valid_q & out_ready;
        next_lane  = CNT_W'(lane_q) + CNT_W'(1);
        more_lanes = next_lane < cnt_q;
        last_hs    = (state_q == ISSUE) & hs & ~more_lanes;
        in_ready   = ~flush & ((state_q == IDLE) | last_hs);
        accept     = in_valid & in_ready;
        eff_cnt    = (in_cnt > CNT_W'(LANES)) ? CNT_W'(LANES) : in_cnt;
        src_sel    = next_lane[LANE_W-1:0];
        src_inst   = accept ? in_inst[31:0] : inst_q[31:0];
        if (!accept) begin
            for (int k = 0; k < int'(LANES); k++) begin
                if (src_sel == LANE_W'(k)) begin
                    src_inst = inst_q[32*k +: 32];
                end
            end
        end
    end

    inst_field_extract u_extract (
        .inst   (src_inst),
        .fields (src_fields)
    );

    // Stage FSM with registered outputs; flush dominates accept and handshake
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= IDLE;
            inst_q      <= '0;
            pc_q        <= '0;
            cnt_q       <= '0;
            lane_q      <= '0;
            out_valid_q <= 1'b0;
            out_pc_q    <= '0;
            fields_q    <= '0;
        end else if (flush) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            lane_q      <= '0;
            out_valid_q <= 1'b0;
        end else if (accept) begin
            if (eff_cnt == '0) begin
                // Empty word: consumed with nothing to issue
                state_q     <= IDLE;
                cnt_q       <= '0;
                lane_q      <= '0;
                out_valid_q <= 1'b0;
            end else begin
                state_q     <= ISSUE;
                inst_q      <= in_inst;
                pc_q        <= in_pc;
                cnt_q       <= eff_cnt;
                lane_q      <= '0;
                out_valid_q <= 1'b1;
                out_pc_q    <= in_pc;
                fields_q    <= src_fields;
            end
        end else if (hs) begin
            if (more_lanes) begin
                lane_q   <= src_sel;
                out_pc_q <= pc_q + (PC_W'(next_lane) << 2);
                fields_q <= src_fields;
            end else begin
                state_q     <= IDLE;
                cnt_q       <= '0;
                lane_q      <= '0;
                out_valid_q <= 1'b0;
            end
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pc         = out_pc_q;
    assign out_opcode     = fields_q.opcode;
    assign out_func3      = fields_q.func3;
    assign out_func7      = fields_q.func7;
    assign out_rs1        = fields_q.rs1;
    assign out_rs2        = fields_q.rs2;
    assign out_rd         = fields_q.rd;
    assign out_csr_info   = fields_q.csr_info;
    assign out_csr_imm    = fields_q.csr_imm;
    assign out_csr_op_imm = fields_q.csr_op_imm;
    assign out_illegal    = fields_q.illegal;

endmodule

// File: tb/tb_multi_lane_decode_stage.sv
// Bench for multi_lane_decode_stage: queue-based reference model checked every
// cycle, plus directed literal expectations.
module tb_multi_lane_decode_stage;

    localparam int LANES = 2;
    localparam int PC_W  = 32;
    localparam int CNT_W = 2;

    logic                clk = 1'b0;
    logic                rstn;
    logic                flush;
    logic                in_valid;
    logic                in_ready;
    logic [LANES*32-1:0] in_inst;
    logic [PC_W-1:0]     in_pc;
    logic [CNT_W-1:0]    in_cnt;
    logic                out_valid;
    logic                out_ready;
    logic [PC_W-1:0]     out_pc;
    logic [4:0]          out_opcode;
    logic [2:0]          out_func3;
    logic [1:0]          out_func7;
    logic [4:0]          out_rs1;
    logic [4:0]          out_rs2;
    logic [4:0]          out_rd;
    logic [21:0]         out_csr_info;
    logic [11:0]         out_csr_imm;
    logic [31:0]         out_csr_op_imm;
    logic                out_illegal;

    multi_lane_decode_stage #(
        .LANES (LANES),
        .PC_W  (PC_W)
    ) dut (
        .clk            (clk),
        .rstn           (rstn),
        .flush          (flush),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_inst        (in_inst),
        .in_pc          (in_pc),
        .in_cnt         (in_cnt),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pc         (out_pc),
        .out_opcode     (out_opcode),
        .out_func3      (out_func3),
        .out_func7      (out_func7),
        .out_rs1        (out_rs1),
        .out_rs2        (out_rs2),
        .out_rd         (out_rd),
        .out_csr_info   (out_csr_info),
        .out_csr_imm    (out_csr_imm),
        .out_csr_op_imm (out_csr_op_imm),
        .out_illegal    (out_illegal)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    logic [91:0] dut_f;
    assign dut_f = {out_opcode, out_func3, out_func7, out_rs1, out_rs2, out_rd,
                    out_csr_info, out_csr_imm, out_csr_op_imm, out_illegal};

    function automatic logic [91:0] exp_fields(input logic [31:0] i);
        return {i[6:2], i[14:12], i[30], i[25], i[19:15], i[24:20], i[11:7],
                i[31:20], i[14:12], i[6:0], i[31:20], 27'd0, i[19:15],
                (i[1:0] != 2'b11)};
    endfunction

    // Reference model: a queue of pending (pc, inst) lanes; head is on the output
    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [31:0]     inst;
    } item_t;

    item_t mq[$];

    always @(posedge clk or negedge rstn) begin
        bit pop;
        bit rdy;
        int n;
        if (!rstn) begin
            mq.delete();
        end else if (flush) begin
            mq.delete();
        end else begin
            pop = (mq.size() != 0) && out_ready;
            rdy = (mq.size() == 0) || ((mq.size() == 1) && out_ready);
            if (pop) void'(mq.pop_front());
            if (in_valid && rdy) begin
                n = (int'(in_cnt) > LANES) ? LANES : int'(in_cnt);
                for (int k = 0; k < n; k++) begin
                    mq.push_back('{pc: in_pc + PC_W'(4 * k), inst: in_inst[32*k +: 32]});
                end
            end
        end
    end

    // Per-cycle compare against the model, away from the active edge
    always @(negedge clk) begin
        bit exp_v;
        bit exp_rdy;
        exp_v   = (mq.size() != 0);
        exp_rdy = !flush && ((mq.size() == 0) || ((mq.size() == 1) && out_ready));
        chk("out_valid", 128'(out_valid), 128'(exp_v));
        chk("in_ready", 128'(in_ready), 128'(exp_rdy));
        if (exp_v) begin
            chk("out_pc", 128'(out_pc), 128'(mq[0].pc));
            chk("fields", 128'(dut_f), 128'(exp_fields(mq[0].inst)));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic word(input logic [PC_W-1:0] pc, input logic [31:0] l1,
                        input logic [31:0] l0, input logic [CNT_W-1:0] cnt);
        in_pc    = pc;
        in_inst  = {l1, l0};
        in_cnt   = cnt;
        in_valid = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [123:0] snap;
        logic [3:0]   rp;
        int           vc;
        rstn      = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        in_inst   = '0;
        in_pc     = '0;
        in_cnt    = '0;
        out_ready = 1'b1;
        #1;
        chk("rst_valid", 128'(out_valid), 128'(0));
        chk("rst_fields", 128'({out_pc, dut_f}), 128'(0));
        repeat (2) @(posedge clk);
        #2 rstn = 1'b1;
        step();
        chk("rst_in_ready", 128'(in_ready), 128'(1));

        // 1: basic two-lane word
        word(32'h100, 32'h0020_8033, 32'h00A0_0093, 2'd2);
        step();
        in_valid = 1'b0;
        chk("t1_l0_valid", 128'(out_valid), 128'(1));
        chk("t1_l0_pc", 128'(out_pc), 128'(32'h100));
        chk("t1_l0_opc", 128'(out_opcode), 128'(5'h04));
        chk("t1_l0_rd", 128'(out_rd), 128'(1));
        chk("t1_l0_rs1", 128'(out_rs1), 128'(0));
        step();
        chk("t1_l1_pc", 128'(out_pc), 128'(32'h104));
        chk("t1_l1_opc", 128'(out_opcode), 128'(5'h0C));
        chk("t1_l1_regs", 128'({out_rs1, out_rs2, out_rd}), 128'({5'd1, 5'd2, 5'd0}));
        chk("t1_l1_f7", 128'(out_func7), 128'(0));
        step();
        chk("t1_done", 128'(out_valid), 128'(0));

        // 2: back-to-back words, no bubble
        vc = 0;
        rp = '0;
        word(32'h200, 32'h0031_01B3, 32'h0010_0113, 2'd2);
        step();
        vc += int'(out_valid);
        rp = {rp[2:0], in_ready};
        word(32'h300, 32'h0000_2083, 32'h0041_8233, 2'd2);
        step();
        vc += int'(out_valid);
        rp = {rp[2:0], in_ready};
        step();
        vc += int'(out_valid);
        rp = {rp[2:0], in_ready};
        in_valid = 1'b0;
        step();
        vc += int'(out_valid);
        rp = {rp[2:0], in_ready};
        chk("t2_valid_run", 128'(vc), 128'(4));
        chk("t2_ready_pulses", 128'(rp), 128'(4'b0101));
        step();
        chk("t2_done", 128'(out_valid), 128'(0));

        // 3: stall on lane 0 for three cycles
        out_ready = 1'b0;
        word(32'h400, 32'h4000_0033, 32'h0050_0113, 2'd2);
        step();
        in_valid = 1'b0;
        snap = {out_pc, dut_f};
        for (int s = 0; s < 3; s++) begin
            step();
            chk("t3_hold", 128'({out_pc, dut_f}), 128'(snap));
            chk("t3_in_ready", 128'(in_ready), 128'(0));
        end
        out_ready = 1'b1;
        step();
        chk("t3_l1_pc", 128'(out_pc), 128'(32'h404));
        chk("t3_l1_f7", 128'(out_func7), 128'(2'b10));
        step();

        // 4: lane count handling
        word(32'h500, 32'hFFFF_FFFF, 32'h00A0_0093, 2'd1);
        step();
        in_valid = 1'b0;
        chk("t4_cnt1_pc", 128'(out_pc), 128'(32'h500));
        step();
        chk("t4_cnt1_done", 128'(out_valid), 128'(0));
        word(32'h600, 32'h0020_8033, 32'h00A0_0093, 2'd3);
        step();
        in_valid = 1'b0;
        step();
        chk("t4_clamp_pc", 128'({out_valid, out_pc}), 128'({1'b1, 32'h604}));
        step();
        chk("t4_clamp_done", 128'(out_valid), 128'(0));
        word(32'h680, 32'h0020_8033, 32'h00A0_0093, 2'd0);
        step();
        in_valid = 1'b0;
        chk("t4_cnt0_valid", 128'(out_valid), 128'(0));
        chk("t4_cnt0_ready", 128'(in_ready), 128'(1));

        // 5: flush beats a stalled lane and a pending word
        out_ready = 1'b0;
        word(32'h700, 32'h0020_8033, 32'h00A0_0093, 2'd2);
        step();
        word(32'h800, 32'h0020_8033, 32'h00A0_0093, 2'd2);
        out_ready = 1'b1;
        flush     = 1'b1;
        step();
        flush    = 1'b0;
        in_valid = 1'b0;
        chk("t5_flush_valid", 128'(out_valid), 128'(0));
        step();
        chk("t5_not_accepted", 128'(out_valid), 128'(0));
        word(32'h900, 32'h0000_0013, 32'h0000_4501, 2'd1);
        step();
        in_valid = 1'b0;
        chk("t5_illegal", 128'({out_valid, out_illegal}), 128'(2'b11));
        step();

        // 6: asynchronous reset mid-word
        out_ready = 1'b0;
        word(32'hA00, 32'h0020_8033, 32'h00A0_0093, 2'd2);
        step();
        in_valid = 1'b0;
        #1 rstn = 1'b0;
        #1;
        chk("t6_async_drop", 128'(out_valid), 128'(0));
        step();
        step();
        rstn = 1'b1;
        step();
        chk("t6_ready", 128'({in_ready, out_valid}), 128'(2'b10));
        out_ready = 1'b1;
        step();
        chk("t6_no_stale", 128'(out_valid), 128'(0));
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
